// File: rtl/uop_buf_ctrl_if.sv
// Bundle-buffer control interface: decode write handshake, fetch read strobe,
// RAM addressing and occupancy. Optional statistics signals exist only when
// UOP_BUF_STATS_EN is defined.
`timescale 1ns/1ps

interface uop_buf_ctrl_if #(
  parameter int unsigned AW = 4
);
  logic          clear;
  logic          wr_valid;
  logic          wr_ready;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic          fetch_stalled;
  logic          rd_enable;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
`ifdef UOP_BUF_STATS_EN
  logic [AW:0]   peak_count;
  logic [31:0]   full_cycles;
`endif

`ifdef UOP_BUF_STATS_EN
  // Pipeline side: drives flush, decode valid and fetch stall.
  modport master (
    output clear, wr_valid, fetch_stalled,
    input  wr_ready, buf_wr_en, buf_wr_addr, rd_enable, rd_addr,
           count, empty, full, peak_count, full_cycles
  );

  // Controller side.
  modport slave (
    input  clear, wr_valid, fetch_stalled,
    output wr_ready, buf_wr_en, buf_wr_addr, rd_enable, rd_addr,
           count, empty, full, peak_count, full_cycles
  );
`else
  // Pipeline side: drives flush, decode valid and fetch stall.
  modport master (
    output clear, wr_valid, fetch_stalled,
    input  wr_ready, buf_wr_en, buf_wr_addr, rd_enable, rd_addr,
           count, empty, full
  );

  // Controller side.
  modport slave (
    input  clear, wr_valid, fetch_stalled,
    output wr_ready, buf_wr_en, buf_wr_addr, rd_enable, rd_addr,
           count, empty, full
  );
`endif
endinterface

// File: rtl/uop_buf_ctrl.sv
// Occupancy/pointer controller for the micro-op bundle buffer between decode
// and uop fetch. Generates RAM write strobe/address, fetch read enables, and
// flushes on pipeline clear.
// Optional feature macro: UOP_BUF_STATS_EN (peak_count and full_cycles).
`timescale 1ns/1ps

module uop_buf_ctrl #(
  parameter int unsigned UOP_BUF_SIZE = 16,
  parameter int unsigned AW           = $clog2(UOP_BUF_SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  uop_buf_ctrl_if.slave      bus
);

  localparam logic [AW:0] SIZE_C    = (AW+1)'(UOP_BUF_SIZE);
  localparam logic [AW:0] SIZE_M1_C = (AW+1)'(UOP_BUF_SIZE - 1);
  localparam logic [AW:0] ONE_C     = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_FLUSH  = 2'd3
  } state_e;

  state_e        state_q;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          empty_q;
  logic          full_q;

  logic          wr_ready_c;
  logic          wr_fire_c;
  logic          rd_fire_c;

  // Handshakes depend only on registered state and the named inputs.
  assign wr_ready_c = ((state_q == ST_EMPTY) || (state_q == ST_ACTIVE)) && !bus.clear;
  assign wr_fire_c  = bus.wr_valid && wr_ready_c;
  assign rd_fire_c  = ((state_q == ST_ACTIVE) || (state_q == ST_FULL)) &&
                      !bus.fetch_stalled && !bus.clear;

  assign bus.wr_ready    = wr_ready_c;
  assign bus.buf_wr_en   = wr_fire_c;
  assign bus.rd_enable   = rd_fire_c;
  assign bus.buf_wr_addr = tail_q;
  assign bus.rd_addr     = head_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign bus.full        = full_q;

  // Next pointers and occupancy; clear and FLUSH both zero the datapath.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.clear || (state_q == ST_FLUSH)) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_fire_c) tail_d = tail_q + AW'(1);
      if (rd_fire_c) head_d = head_q + AW'(1);
      if (wr_fire_c && !rd_fire_c) begin
        count_d = count_q + ONE_C;
      end else if (rd_fire_c && !wr_fire_c) begin
        count_d = count_q - ONE_C;
      end
    end
  end

  // State machine plus registered pointers, occupancy and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == SIZE_C);
      if (bus.clear) begin
        state_q <= ST_FLUSH;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (wr_fire_c) state_q <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (wr_fire_c && !rd_fire_c && (count_q == SIZE_M1_C)) begin
              state_q <= ST_FULL;
            end else if (rd_fire_c && !wr_fire_c && (count_q == ONE_C)) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (rd_fire_c) state_q <= ST_ACTIVE;
          end
          ST_FLUSH: begin
            state_q <= ST_EMPTY;
          end
          default: begin
            state_q <= ST_EMPTY;
          end
        endcase
      end
    end
  end

`ifdef UOP_BUF_STATS_EN
  logic [AW:0] peak_count_q;
  logic [31:0] full_cycles_q;

  assign bus.peak_count  = peak_count_q;
  assign bus.full_cycles = full_cycles_q;

  // High-water mark (reset by clear) and saturating FULL-cycle counter (reset only).
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_count_q  <= '0;
      full_cycles_q <= '0;
    end else begin
      if (bus.clear) begin
        peak_count_q <= '0;
      end else if (count_d > peak_count_q) begin
        peak_count_q <= count_d;
      end
      if ((state_q == ST_FULL) && (full_cycles_q != 32'hFFFF_FFFF)) begin
        full_cycles_q <= full_cycles_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uop_buf_ctrl.sv
// Self-checking bench for uop_buf_ctrl: a negedge monitor keeps a reference
// model and an address scoreboard (write addresses pushed on accept, popped
// and matched against rd_addr on each read); scenario tasks add inline checks.
`timescale 1ns/1ps

module tb_uop_buf_ctrl;

  localparam int unsigned SIZE = 16;
  localparam int unsigned AW   = 4;
  localparam int M_E  = 0;
  localparam int M_A  = 1;
  localparam int M_F  = 2;
  localparam int M_FL = 3;

  logic clk;
  logic reset;

  uop_buf_ctrl_if #(.AW(AW)) bus ();

  uop_buf_ctrl #(.UOP_BUF_SIZE(SIZE), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit mon_en = 1'b0;
  int ms;
  int mcount;
  int mtail;
  int sb[$];
  bit exp_wr, exp_rd, wfire;
  int exp_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: compare handshakes/occupancy to the model, run the scoreboard, advance model.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_wr = ((ms == M_E) || (ms == M_A)) && !bus.clear;
      exp_rd = ((ms == M_A) || (ms == M_F)) && !bus.fetch_stalled && !bus.clear;
      wfire  = exp_wr && bus.wr_valid;

      n_cmp++;
      if (bus.wr_ready !== exp_wr) begin
        n_err++;
        $display("FAIL mon_wr_ready t=%0t got %b exp %b", $time, bus.wr_ready, exp_wr);
      end
      n_cmp++;
      if (bus.rd_enable !== exp_rd) begin
        n_err++;
        $display("FAIL mon_rd_enable t=%0t got %b exp %b", $time, bus.rd_enable, exp_rd);
      end
      n_cmp++;
      if (bus.buf_wr_en !== wfire) begin
        n_err++;
        $display("FAIL mon_buf_wr_en t=%0t got %b exp %b", $time, bus.buf_wr_en, wfire);
      end
      n_cmp++;
      if ({bus.count, bus.empty, bus.full} !== {5'(mcount), (mcount == 0), (mcount == SIZE)}) begin
        n_err++;
        $display("FAIL mon_occupancy t=%0t got count=%0d empty=%b full=%b exp count=%0d",
                 $time, bus.count, bus.empty, bus.full, mcount);
      end

      if (wfire) begin
        n_cmp++;
        if (bus.buf_wr_addr !== 4'(mtail)) begin
          n_err++;
          $display("FAIL mon_wr_addr t=%0t got %0d exp %0d", $time, bus.buf_wr_addr, mtail);
        end
        sb.push_back(mtail);
        mtail = (mtail + 1) % SIZE;
      end

      if (exp_rd) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow t=%0t read with no resident bundle", $time);
        end else begin
          exp_a = sb.pop_front();
          if (bus.rd_addr !== 4'(exp_a)) begin
            n_err++;
            $display("FAIL sb_rd_addr t=%0t got %0d exp %0d", $time, bus.rd_addr, exp_a);
          end
        end
      end

      if (bus.clear) begin
        ms     = M_FL;
        mcount = 0;
        mtail  = 0;
        sb.delete();
      end else begin
        mcount = mcount + (wfire ? 1 : 0) - (exp_rd ? 1 : 0);
        case (ms)
          M_E:     if (wfire) ms = M_A;
          M_A:     if (mcount == SIZE) ms = M_F; else if (mcount == 0) ms = M_E;
          M_F:     if (exp_rd) ms = M_A;
          default: ms = M_E;
        endcase
      end
    end
  end

  task automatic drive(input bit wv, input bit st, input bit cl);
    bus.wr_valid      = wv;
    bus.fetch_stalled = st;
    bus.clear         = cl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    ms     = M_E;
    mcount = 0;
    mtail  = 0;
    sb.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.wr_ready, bus.buf_wr_en, bus.buf_wr_addr, bus.rd_enable, bus.rd_addr,
         bus.count, bus.empty, bus.full} !== {1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 5'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs got wr_ready=%b wr_en=%b wr_addr=%0d rd_en=%b rd_addr=%0d count=%0d empty=%b full=%b exp 1 0 0 0 0 0 1 0",
               bus.wr_ready, bus.buf_wr_en, bus.buf_wr_addr, bus.rd_enable, bus.rd_addr,
               bus.count, bus.empty, bus.full);
    end
    model_init();
  endtask

  task automatic test_fill();
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if ({bus.buf_wr_addr, bus.wr_ready, bus.rd_enable} !== {4'(i), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL fill_write[%0d] got addr=%0d wr_ready=%b rd_en=%b exp addr=%0d 1 0",
                 i, bus.buf_wr_addr, bus.wr_ready, bus.rd_enable, i);
      end
      tick();
    end
    drive(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.wr_ready, bus.buf_wr_en, bus.full, bus.count, bus.rd_enable} !==
        {1'b0, 1'b0, 1'b1, 5'd16, 1'b0}) begin
      n_err++;
      $display("FAIL fill_full got wr_ready=%b wr_en=%b full=%b count=%0d rd_en=%b exp 0 0 1 16 0",
               bus.wr_ready, bus.buf_wr_en, bus.full, bus.count, bus.rd_enable);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.count !== 5'd16) begin
      n_err++;
      $display("FAIL fill_no_overflow got count=%0d exp 16", bus.count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if ({bus.rd_enable, bus.rd_addr} !== {1'b1, 4'(i)}) begin
        n_err++;
        $display("FAIL drain_read[%0d] got rd_en=%b rd_addr=%0d exp 1 %0d",
                 i, bus.rd_enable, bus.rd_addr, i);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.empty, bus.count, bus.rd_enable, bus.wr_ready} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL drain_empty got empty=%b count=%0d rd_en=%b wr_ready=%b exp 1 0 0 1",
               bus.empty, bus.count, bus.rd_enable, bus.wr_ready);
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.buf_wr_en, bus.rd_enable} !== {1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL latency_same_cycle got wr_en=%b rd_en=%b exp 1 0", bus.buf_wr_en, bus.rd_enable);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.rd_enable, bus.count} !== {1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL latency_next_cycle got rd_en=%b count=%0d exp 1 1", bus.rd_enable, bus.count);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.rd_enable, bus.count, bus.empty} !== {1'b0, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL latency_consumed got rd_en=%b count=%0d empty=%b exp 0 0 1",
               bus.rd_enable, bus.count, bus.empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if ({bus.count, bus.rd_enable, bus.wr_ready, bus.full, bus.empty} !==
          {5'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL b2b[%0d] got count=%0d rd_en=%b wr_ready=%b full=%b empty=%b exp 3 1 1 0 0",
                 i, bus.count, bus.rd_enable, bus.wr_ready, bus.full, bus.empty);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.empty, bus.count} !== {1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL b2b_drained got empty=%b count=%0d exp 1 0", bus.empty, bus.count);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.count, bus.wr_ready, bus.buf_wr_en, bus.rd_enable} !== {5'd9, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL clear_cycle got count=%0d wr_ready=%b wr_en=%b rd_en=%b exp 9 0 0 0",
               bus.count, bus.wr_ready, bus.buf_wr_en, bus.rd_enable);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.wr_ready, bus.buf_wr_en, bus.rd_enable, bus.count, bus.rd_addr, bus.buf_wr_addr} !==
        {1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0}) begin
      n_err++;
      $display("FAIL flush_cycle got wr_ready=%b wr_en=%b rd_en=%b count=%0d rd_addr=%0d wr_addr=%0d exp 0 0 0 0 0 0",
               bus.wr_ready, bus.buf_wr_en, bus.rd_enable, bus.count, bus.rd_addr, bus.buf_wr_addr);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.wr_ready, bus.empty, bus.count} !== {1'b1, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL clear_recovered got wr_ready=%b empty=%b count=%0d exp 1 1 0",
               bus.wr_ready, bus.empty, bus.count);
    end
    tick();
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    drive(1'b1, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.wr_ready, bus.count, bus.empty, bus.buf_wr_addr} !== {1'b1, 5'd0, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL reset_over_clear got wr_ready=%b count=%0d empty=%b wr_addr=%0d exp 1 0 1 0",
               bus.wr_ready, bus.count, bus.empty, bus.buf_wr_addr);
    end
    model_init();
  endtask

`ifdef UOP_BUF_STATS_EN
  task automatic test_stats();
    test_reset();
    n_cmp++;
    if ({bus.peak_count, bus.full_cycles} !== {5'd0, 32'd0}) begin
      n_err++;
      $display("FAIL stats_reset got peak=%0d full_cycles=%0d exp 0 0", bus.peak_count, bus.full_cycles);
    end
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < SIZE; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({bus.peak_count, bus.full_cycles} !== {5'd16, 32'd6}) begin
      n_err++;
      $display("FAIL stats_after_drain got peak=%0d full_cycles=%0d exp 16 6", bus.peak_count, bus.full_cycles);
    end
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({bus.peak_count, bus.full_cycles} !== {5'd0, 32'd6}) begin
      n_err++;
      $display("FAIL stats_after_clear got peak=%0d full_cycles=%0d exp 0 6", bus.peak_count, bus.full_cycles);
    end
  endtask
`endif

  initial begin
    reset             = 1'b1;
    bus.clear         = 1'b0;
    bus.wr_valid      = 1'b0;
    bus.fetch_stalled = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_back_to_back();
    test_clear();
    test_reset_priority();
`ifdef UOP_BUF_STATS_EN
    test_stats();
`endif
    drive(1'b0, 1'b1, 1'b0);
    tick();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
